// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM feeding alu_control; counts retired instructions.
// Define MEM_WAIT_EN to stall memory states on mem_ready with a timeout.
module mc_main_control #(
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [2:0]       ALUop,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             alu_src_imm,
  output logic             reg_dst_rd,
  output logic             mem_to_reg,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             jump,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_IFETCH, S_DECODE, S_EXEC_R,
    S_WB_R, S_ADDR, S_MEM_RD, S_WB_MEM,
    S_MEM_WR, S_BRANCH, S_EXEC_I, S_WB_I,
    S_JUMP, S_ILLEGAL
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_ok;
  logic             wait_exp;
  logic             tmo_set;
  state_t           final_nxt;

  assign final_nxt = run ? S_IFETCH : S_IDLE;

`ifdef MEM_WAIT_EN
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WLAST = WW'(WAIT_LIMIT - 1);

  logic [WW-1:0] wait_q;
  logic          to_q;

  assign mem_ok      = mem_ready;
  assign wait_exp    = !mem_ready && (wait_q == WLAST);
  assign mem_timeout = to_q;

  // Counter restarts whenever a new state is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wait_q <= (state_d != state_q) ? '0 : wait_q + 1'b1;
      if (tmo_set) to_q <= 1'b1;
    end
  end
`else
  logic unused_sig;

  assign mem_ok      = 1'b1;
  assign wait_exp    = 1'b0;
  assign mem_timeout = 1'b0;
  assign unused_sig  = ^{mem_ready, tmo_set, (WAIT_LIMIT == 0)};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tmo_set = 1'b0;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_IFETCH;
      S_IFETCH: begin
        if (mem_ok) state_d = S_DECODE;
        else if (wait_exp) begin
          state_d = S_IDLE;
          tmo_set = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        unique case (1'b1)
          (opcode == OP_R):  state_d = S_EXEC_R;
          (opcode == OP_LW),
          (opcode == OP_SW): state_d = S_ADDR;
          (opcode == OP_BEQ),
          (opcode == OP_BNE): state_d = S_BRANCH;
          (opcode == OP_ADDI),
          (opcode == OP_ANDI),
          (opcode == OP_ORI),
          (opcode == OP_SLTI): state_d = S_EXEC_I;
          (opcode == OP_J):  state_d = S_JUMP;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_ADDR:   state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ok) state_d = S_WB_MEM;
        else if (wait_exp) begin
          state_d = S_IDLE;
          tmo_set = 1'b1;
        end
      end
      S_MEM_WR: begin
        if (mem_ok) state_d = final_nxt;
        else if (wait_exp) begin
          state_d = S_IDLE;
          tmo_set = 1'b1;
        end
      end
      S_EXEC_I: state_d = S_WB_I;
      S_WB_R, S_WB_MEM, S_BRANCH,
      S_WB_I, S_JUMP, S_ILLEGAL: state_d = final_nxt;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ALUop       = 3'b000;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    alu_src_imm = 1'b0;
    reg_dst_rd  = 1'b0;
    mem_to_reg  = 1'b0;
    branch_eq   = 1'b0;
    branch_ne   = 1'b0;
    jump        = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    unique case (state_q)
      S_IFETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_EXEC_R: ALUop = 3'b111;
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst_rd = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDR:   alu_src_imm = 1'b1;
      S_MEM_RD: mem_read = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      // A stalled store only retires once memory accepts it.
      S_MEM_WR: begin
        mem_write  = 1'b1;
        instr_done = mem_ok;
      end
      S_BRANCH: begin
        ALUop      = 3'b001;
        branch_eq  = (op_q == OP_BEQ);
        branch_ne  = (op_q == OP_BNE);
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_imm = 1'b1;
        unique case (1'b1)
          (op_q == OP_ANDI): ALUop = 3'b100;
          (op_q == OP_ORI):  ALUop = 3'b101;
          (op_q == OP_SLTI): ALUop = 3'b110;
          default:           ALUop = 3'b000;
        endcase
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        jump       = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign retired_d = instr_done ? retired_q + CNT_W'(1) : retired_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: per-instruction cycle-table model.
// Second instance with a 2-bit counter exercises counter wrap.
module tb_mc_main_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, run, mem_ready;
  logic [5:0]  opcode;
  logic [2:0]  ALUop;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write;
  logic        alu_src_imm, reg_dst_rd, mem_to_reg;
  logic        branch_eq, branch_ne, jump, instr_done, illegal_op;
  logic        mem_timeout;
  logic [15:0] retired;

  logic [2:0]  s_ALUop;
  logic        s_pc_write, s_ir_write, s_mem_read, s_mem_write;
  logic        s_reg_write, s_alu_src_imm, s_reg_dst_rd, s_mem_to_reg;
  logic        s_branch_eq, s_branch_ne, s_jump, s_instr_done;
  logic        s_illegal_op, s_mem_timeout;
  logic [1:0]  s_retired;

  mc_main_control #(.CNT_W(16), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .mem_ready(mem_ready), .ALUop(ALUop), .pc_write(pc_write),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_imm(alu_src_imm),
    .reg_dst_rd(reg_dst_rd), .mem_to_reg(mem_to_reg),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .retired(retired)
  );

  mc_main_control #(.CNT_W(2), .WAIT_LIMIT(15)) dut_small (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .mem_ready(mem_ready), .ALUop(s_ALUop), .pc_write(s_pc_write),
    .ir_write(s_ir_write), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .reg_write(s_reg_write),
    .alu_src_imm(s_alu_src_imm), .reg_dst_rd(s_reg_dst_rd),
    .mem_to_reg(s_mem_to_reg), .branch_eq(s_branch_eq),
    .branch_ne(s_branch_ne), .jump(s_jump),
    .instr_done(s_instr_done), .illegal_op(s_illegal_op),
    .mem_timeout(s_mem_timeout), .retired(s_retired)
  );

  int         vectors = 0;
  int         errors  = 0;
  logic [5:0] cur_op;
  int         cur_k;
  int         exp_ret;
  logic       exp_to;
  logic       chk_en;

  function automatic int ilen(input logic [5:0] op);
    case (op)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return 4;
      default:   return 3;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction (k<0: idle).
  // Order: ALUop, pc, ir, mrd, mwr, rw, imm, rd, m2r, beq, bne, j, done, ill
  function automatic logic [15:0] sig(input logic [5:0] op, input int k);
    logic [2:0] alu;
    logic pcw, irw, mr, mw, rw, src, rd, m2r, beq, bne, jmp, done, ill;
    {alu, pcw, irw, mr, mw, rw, src, rd, m2r, beq, bne, jmp, done, ill} = '0;
    if (k == 0) begin
      pcw = 1; irw = 1; mr = 1;
    end else if (k >= 2) begin
      case (op)
        6'b000000:
          if (k == 2) alu = 3'b111;
          else begin rw = 1; rd = 1; done = 1; end
        6'b100011:
          if (k == 2) src = 1;
          else if (k == 3) mr = 1;
          else begin rw = 1; m2r = 1; done = 1; end
        6'b101011:
          if (k == 2) src = 1;
          else begin mw = 1; done = 1; end
        6'b000100: begin alu = 3'b001; beq = 1; done = 1; end
        6'b000101: begin alu = 3'b001; bne = 1; done = 1; end
        6'b000010: begin jmp = 1; done = 1; end
        6'b001000, 6'b001100, 6'b001101, 6'b001010:
          if (k == 2) begin
            src = 1;
            alu = (op == 6'b001100) ? 3'b100 :
                  (op == 6'b001101) ? 3'b101 :
                  (op == 6'b001010) ? 3'b110 : 3'b000;
          end else begin
            rw = 1; done = 1;
          end
        default: ill = 1;
      endcase
    end
    return {alu, pcw, irw, mr, mw, rw, src, rd, m2r, beq, bne, jmp, done, ill};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs",
          {ALUop, pc_write, ir_write, mem_read, mem_write, reg_write,
           alu_src_imm, reg_dst_rd, mem_to_reg, branch_eq, branch_ne,
           jump, instr_done, illegal_op},
          sig(cur_op, cur_k));
      chk("retired", retired, exp_ret[15:0]);
      chk("retired_w2", s_retired, exp_ret[1:0]);
      chk("mem_timeout", mem_timeout, exp_to);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cur_k = -1;
      tick();
    end
  endtask

  // Opcode is scrambled after DECODE to prove it was latched.
  task automatic do_instr(input logic [5:0] op, input logic run_val,
                          input int rst_at);
    int n;
    logic [15:0] last;
    n = ilen(op);
    for (int k = 0; k < n; k++) begin
      cur_op = op;
      cur_k  = k;
      opcode = (k >= 2) ? ~op : op;
      if (k == 2) run = run_val;
      if (k == rst_at) rst_n = 1'b0;
      tick();
      if (k == rst_at) begin
        exp_ret = 0;
        cur_k   = -1;
        return;
      end
    end
    last = sig(op, n - 1);
    if (!last[0]) exp_ret++;
    cur_k = -1;
  endtask

  logic [5:0] itype [4];

  initial begin
    itype[0] = 6'b001000;
    itype[1] = 6'b001100;
    itype[2] = 6'b001101;
    itype[3] = 6'b001010;
    rst_n = 1'b0; run = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
    cur_op = '0; cur_k = -1; exp_ret = 0; exp_to = 1'b0; chk_en = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_retired", retired, 32'd0);
    rst_n = 1'b1;
    idle(1);
    do_instr(6'b000000, 1'b1, -1);
    chk("r_retired", retired, 32'd1);
    do_instr(6'b100011, 1'b1, -1);
    do_instr(6'b101011, 1'b1, -1);
    chk("lwsw_retired", retired, 32'd3);
    for (int i = 0; i < 4; i++) begin
      do_instr(itype[i], 1'b1, -1);
      if (i == 0) chk("wrap_w2", s_retired, 32'd0);
    end
    do_instr(6'b000101, 1'b1, -1);
    do_instr(6'b000100, 1'b1, -1);
    do_instr(6'b000010, 1'b1, -1);
    do_instr(6'b111111, 1'b1, -1);
    chk("illegal_retired", retired, 32'd10);
    do_instr(6'b000000, 1'b0, -1);
    idle(2);
    run = 1'b1;
    idle(1);
    do_instr(6'b100011, 1'b1, 3);
    chk("abort_retired", retired, 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    do_instr(6'b000000, 1'b1, -1);
    chk("post_rst_retired", retired, 32'd1);
    do_instr(6'b001000, 1'b0, -1);
    idle(2);
`ifdef MEM_WAIT_EN
    run = 1'b1;
    idle(1);
    mem_ready = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cur_op = 6'b000000;
      cur_k  = 0;
      tick();
    end
    exp_to = 1'b1;
    idle(3);
    chk("timeout_flag", mem_timeout, 32'd1);
`endif
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
